// File: rtl/harmonic_sequencer_pkg.sv
// Shared synthesis constants for the harmonic sequencer and its adder.
// The package holds the state encoding, the 16-bit saturation limits and the harmonic bound.
package harmonic_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_START,
    S_GUARD,
    S_WAIT,
    S_NEXT,
    S_OUTPUT
  } state_t;

  localparam int MAX_HARMONICS_DEFAULT = 64;

  localparam logic signed [31:0] SAT_MAX = 32'sd32767;
  localparam logic signed [31:0] SAT_MIN = -32'sd32768;

endpackage

// File: rtl/saturate_32_to_16.sv
// Combinational clamp of a signed 32-bit accumulator into the signed 16-bit range.
module saturate_32_to_16
  import harmonic_sequencer_pkg::*;
(
  input  logic signed [31:0] value,
  output logic signed [15:0] result
);

  always_comb begin
    if (value > SAT_MAX) begin
      result = SAT_MAX[15:0];
    end else if (value < SAT_MIN) begin
      result = SAT_MIN[15:0];
    end else begin
      result = value[15:0];
    end
  end

endmodule

// File: rtl/harmonic_sequencer.sv
// Steps through N harmonics, feeding table samples to an external multiply-accumulate
// adder, then saturates the running total into one 16-bit output sample.
module harmonic_sequencer
  import harmonic_sequencer_pkg::*;
#(
  parameter int MAX_HARMONICS = MAX_HARMONICS_DEFAULT,
  parameter int DONE_TIMEOUT  = 15
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Sample_Req,
  input  logic [6:0]         i_Harmonic_Count,
  output logic [5:0]         o_Harmonic,
  input  logic signed [15:0] i_Sine,
  input  logic signed [15:0] i_Scale,
  output logic               o_Start,
  output logic signed [15:0] o_Multiple,
  output logic signed [15:0] o_Sample,
  output logic               o_Clear_Accumulator,
  input  logic               i_Adder_Done,
  input  logic signed [31:0] i_Accumulator,
  output logic signed [15:0] o_Output_Sample,
  output logic               o_Sample_Valid,
  output logic               o_Busy,
  output logic               o_Overrun,
  output logic               o_Error
);

  localparam int                WAIT_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [6:0]        MAX_N     = 7'(MAX_HARMONICS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DONE_TIMEOUT - 1);

  state_t             state;
  state_t             state_next;
  logic [6:0]         n;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               timeout;
  logic               last_harmonic;
  logic signed [15:0] saturated;

  saturate_32_to_16 u_saturate (
    .value  (i_Accumulator),
    .result (saturated)
  );

  assign timeout       = (state == S_WAIT) && !i_Adder_Done && (wait_cnt == WAIT_LAST);
  assign last_harmonic = ({1'b0, o_Harmonic} + 7'd1) >= n;
  assign o_Busy        = (state != S_IDLE);
  // Requests arriving while busy (OUTPUT included) are dropped and only flagged.
  assign o_Overrun     = i_Sample_Req && o_Busy;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next          = state;
    o_Start             = 1'b0;
    o_Clear_Accumulator = 1'b0;
    case (state)
      S_IDLE:   if (i_Sample_Req) state_next = S_CLEAR;
      S_CLEAR: begin
        o_Clear_Accumulator = 1'b1;
        state_next          = (n == '0) ? S_OUTPUT : S_FETCH;
      end
      S_FETCH:  state_next = S_START;
      S_START: begin
        o_Start    = 1'b1;
        state_next = S_GUARD;
      end
      // The adder lowers its done flag one cycle late, so GUARD never looks at it.
      S_GUARD:  state_next = S_WAIT;
      S_WAIT: begin
        if (i_Adder_Done) begin
          state_next = S_NEXT;
        end else if (timeout) begin
          o_Clear_Accumulator = 1'b1;
          state_next          = S_IDLE;
        end
      end
      S_NEXT:   state_next = last_harmonic ? S_OUTPUT : S_FETCH;
      S_OUTPUT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      n               <= '0;
      wait_cnt        <= '0;
      o_Harmonic      <= '0;
      o_Multiple      <= '0;
      o_Sample        <= '0;
      o_Output_Sample <= '0;
      o_Sample_Valid  <= 1'b0;
      o_Error         <= 1'b0;
    end else begin
      o_Sample_Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Sample_Req) begin
            n          <= (i_Harmonic_Count > MAX_N) ? MAX_N : i_Harmonic_Count;
            o_Harmonic <= '0;
          end
        end
        S_FETCH: begin
          o_Multiple <= i_Scale;
          o_Sample   <= i_Sine;
        end
        S_GUARD:  wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (timeout) o_Error <= 1'b1;
        end
        S_NEXT:   if (!last_harmonic) o_Harmonic <= o_Harmonic + 6'd1;
        S_OUTPUT: begin
          o_Output_Sample <= saturated;
          o_Sample_Valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Self-checking bench: behavioural adder and tables, row-driven vectors plus
// directed overrun, timeout and mid-computation reset sequences.
module tb_harmonic_sequencer;
  import harmonic_sequencer_pkg::*;

  localparam int DIVISOR_BITS = 9;

  logic               i_Clock;
  logic               i_Reset;
  logic               i_Sample_Req;
  logic [6:0]         i_Harmonic_Count;
  logic [5:0]         o_Harmonic;
  logic signed [15:0] i_Sine;
  logic signed [15:0] i_Scale;
  logic               o_Start;
  logic signed [15:0] o_Multiple;
  logic signed [15:0] o_Sample;
  logic               o_Clear_Accumulator;
  logic               i_Adder_Done;
  logic signed [31:0] i_Accumulator;
  logic signed [15:0] o_Output_Sample;
  logic               o_Sample_Valid;
  logic               o_Busy;
  logic               o_Overrun;
  logic               o_Error;

  harmonic_sequencer dut (
    .i_Clock             (i_Clock),
    .i_Reset             (i_Reset),
    .i_Sample_Req        (i_Sample_Req),
    .i_Harmonic_Count    (i_Harmonic_Count),
    .o_Harmonic          (o_Harmonic),
    .i_Sine              (i_Sine),
    .i_Scale             (i_Scale),
    .o_Start             (o_Start),
    .o_Multiple          (o_Multiple),
    .o_Sample            (o_Sample),
    .o_Clear_Accumulator (o_Clear_Accumulator),
    .i_Adder_Done        (i_Adder_Done),
    .i_Accumulator       (i_Accumulator),
    .o_Output_Sample     (o_Output_Sample),
    .o_Sample_Valid      (o_Sample_Valid),
    .o_Busy              (o_Busy),
    .o_Overrun           (o_Overrun),
    .o_Error             (o_Error)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // Tables answer combinationally, well inside the one-cycle table latency.
  logic signed [15:0] sine_tab  [64];
  logic signed [15:0] scale_tab [64];
  assign i_Sine  = sine_tab[o_Harmonic];
  assign i_Scale = scale_tab[o_Harmonic];

  // Behavioural adder: total += (multiple*sample) >>> DIVISOR_BITS, done low one cycle after start.
  logic signed [31:0] acc;
  logic signed [31:0] prod;
  logic               adder_done_q;
  logic               hold_done_low;
  logic               force_en;
  logic signed [31:0] force_val;

  assign prod = o_Multiple * o_Sample;
  always @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      acc          <= '0;
      adder_done_q <= 1'b1;
    end else begin
      if (o_Clear_Accumulator) acc <= '0;
      else if (o_Start)        acc <= acc + (prod >>> DIVISOR_BITS);
      adder_done_q <= hold_done_low ? 1'b0 : !o_Start;
    end
  end
  assign i_Adder_Done  = adder_done_q;
  assign i_Accumulator = force_en ? force_val : acc;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    int sample;
    int due;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  int cyc        = 0;
  int start_cnt  = 0;
  int clr_cnt    = 0;
  int valid_cnt  = 0;
  int ovr_cnt    = 0;
  int run_max    = 0;
  int last_peak  = 0;

  always @(negedge i_Clock) begin
    if (i_Reset) begin
      run_max = 0;
    end else begin
      if (o_Start)             start_cnt++;
      if (o_Clear_Accumulator) clr_cnt++;
      if (o_Overrun)           ovr_cnt++;
      if (o_Sample_Valid) begin
        valid_cnt++;
        last_peak = run_max;
        run_max   = 0;
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          sb_e = sb.pop_front();
          check("sample", int'(o_Output_Sample), sb_e.sample);
          check("latency", cyc, sb_e.due);
        end
      end else if (!o_Busy) begin
        run_max = 0;
      end else if (int'(o_Harmonic) > run_max) begin
        run_max = int'(o_Harmonic);
      end
    end
    cyc++;
  end

  typedef struct {
    int                 count;
    logic signed [15:0] sine;
    logic signed [15:0] scale;
    bit                 fen;
    logic signed [31:0] fval;
    int                 exp_sample;
    int                 exp_starts;
  } vec_t;

  function automatic vec_t mk(input int count, input int sine, input int scale, input bit fen,
                              input logic [31:0] fval, input int exp_sample, input int exp_starts);
    vec_t v;
    v.count      = count;
    v.sine       = 16'(sine);
    v.scale      = 16'(scale);
    v.fen        = fen;
    v.fval       = fval;
    v.exp_sample = exp_sample;
    v.exp_starts = exp_starts;
    return v;
  endfunction

  task automatic issue_req(input int count, input bit push, input int exp_sample, input int lat);
    sb_t e;
    @(posedge i_Clock); #1;
    i_Harmonic_Count = 7'(count);
    i_Sample_Req     = 1'b1;
    if (push) begin
      e.sample = exp_sample;
      e.due    = cyc + lat;
      sb.push_back(e);
    end
    @(posedge i_Clock); #1;
    i_Sample_Req = 1'b0;
  endtask

  task automatic wait_valid(input int v0, input int budget);
    int i = 0;
    while (valid_cnt == v0 && i < budget) begin
      @(posedge i_Clock); #1;
      i++;
    end
    check("valid_seen", valid_cnt - v0, 1);
    if (valid_cnt == v0) sb.delete();
  endtask

  task automatic wait_harmonic(input int h);
    int i = 0;
    while (int'(o_Harmonic) != h && i < 40) begin
      @(posedge i_Clock); #1;
      i++;
    end
    check("reach_harmonic", int'(o_Harmonic), h);
  endtask

  task automatic run_row(input vec_t v);
    int s0, c0, v0, o0, lat;
    for (int h = 0; h < 64; h++) begin
      sine_tab[h]  = v.sine;
      scale_tab[h] = v.scale;
    end
    force_en  = v.fen;
    force_val = v.fval;
    s0 = start_cnt; c0 = clr_cnt; v0 = valid_cnt; o0 = ovr_cnt;
    lat = 3 + 5 * v.exp_starts;
    issue_req(v.count, 1'b1, v.exp_sample, lat);
    wait_valid(v0, lat + 10);
    check("starts", start_cnt - s0, v.exp_starts);
    check("clears", clr_cnt - c0, 1);
    check("overruns", ovr_cnt - o0, 0);
    check("busy_after", int'(o_Busy), 0);
    if (v.exp_starts > 0) check("peak_harmonic", last_peak, v.exp_starts - 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_harmonic"}, int'(o_Harmonic), 0);
    check({tag, "_multiple"}, int'(o_Multiple), 0);
    check({tag, "_sample"},   int'(o_Sample), 0);
    check({tag, "_start"},    int'(o_Start), 0);
    check({tag, "_clear"},    int'(o_Clear_Accumulator), 0);
    check({tag, "_out"},      int'(o_Output_Sample), 0);
    check({tag, "_valid"},    int'(o_Sample_Valid), 0);
    check({tag, "_busy"},     int'(o_Busy), 0);
    check({tag, "_overrun"},  int'(o_Overrun), 0);
    check({tag, "_error"},    int'(o_Error), 0);
  endtask

  vec_t vecs[14];

  initial begin
    int s0, c0, v0, o0, k;

    vecs[0]  = mk(0,   1000,   256,   0, 32'h0,         0,      0);
    vecs[1]  = mk(1,   1000,   256,   0, 32'h0,         500,    1);
    vecs[2]  = mk(3,   1000,   256,   0, 32'h0,         1500,   3);
    vecs[3]  = mk(2,   -2000,  512,   0, 32'h0,         -4000,  2);
    vecs[4]  = mk(5,   32767,  32767, 0, 32'h0,         32767,  5);
    vecs[5]  = mk(4,   -32768, 32767, 0, 32'h0,         -32768, 4);
    vecs[6]  = mk(100, 256,    2,     0, 32'h0,         64,     64);
    vecs[7]  = mk(64,  512,    1,     0, 32'h0,         64,     64);
    vecs[8]  = mk(0,   0,      0,     1, 32'h0001_0000, 32767,  0);
    vecs[9]  = mk(0,   0,      0,     1, 32'hFFFE_0000, -32768, 0);
    vecs[10] = mk(0,   0,      0,     1, 32'h0000_7FFF, 32767,  0);
    vecs[11] = mk(0,   0,      0,     1, 32'hFFFF_8000, -32768, 0);
    vecs[12] = mk(0,   0,      0,     1, 32'h0000_8000, 32767,  0);
    vecs[13] = mk(0,   0,      0,     1, 32'hFFFF_7FFF, -32768, 0);

    for (int h = 0; h < 64; h++) begin
      sine_tab[h]  = '0;
      scale_tab[h] = '0;
    end
    i_Sample_Req     = 1'b0;
    i_Harmonic_Count = '0;
    hold_done_low    = 1'b0;
    force_en         = 1'b0;
    force_val        = '0;
    i_Reset          = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;

    for (int i = 0; i < 14; i++) run_row(vecs[i]);
    force_en = 1'b0;

    // Request during harmonic 1 of 3: dropped, result and timing untouched.
    for (int h = 0; h < 64; h++) begin
      sine_tab[h]  = 16'sd1000;
      scale_tab[h] = 16'sd256;
    end
    s0 = start_cnt; v0 = valid_cnt; o0 = ovr_cnt;
    issue_req(3, 1'b1, 1500, 18);
    wait_harmonic(1);
    issue_req(0, 1'b0, 0, 0);
    wait_valid(v0, 30);
    repeat (5) @(posedge i_Clock);
    #1;
    check("mid_overrun_pulses", ovr_cnt - o0, 1);
    check("mid_overrun_starts", start_cnt - s0, 3);
    check("mid_overrun_valids", valid_cnt - v0, 1);

    // Request landing on the OUTPUT cycle (cycle 7 for N=1) is also an overrun.
    s0 = start_cnt; v0 = valid_cnt; o0 = ovr_cnt;
    issue_req(1, 1'b1, 500, 8);
    repeat (6) @(posedge i_Clock);
    #1;
    i_Harmonic_Count = 7'd2;
    i_Sample_Req     = 1'b1;
    @(posedge i_Clock); #1;
    i_Sample_Req = 1'b0;
    wait_valid(v0, 10);
    repeat (5) @(posedge i_Clock);
    #1;
    check("out_overrun_pulses", ovr_cnt - o0, 1);
    check("out_overrun_starts", start_cnt - s0, 1);
    check("out_overrun_valids", valid_cnt - v0, 1);
    check("out_overrun_idle", int'(o_Busy), 0);

    // Adder never completes: error after 15 WAIT cycles, visible at cycle 20.
    hold_done_low = 1'b1;
    s0 = start_cnt; c0 = clr_cnt; v0 = valid_cnt;
    issue_req(2, 1'b0, 0, 0);
    k = 1;
    while (!o_Error && k < 40) begin
      @(posedge i_Clock); #1;
      k++;
    end
    check("timeout_cycle", k, 20);
    check("timeout_error", int'(o_Error), 1);
    check("timeout_idle", int'(o_Busy), 0);
    repeat (3) @(posedge i_Clock);
    #1;
    check("timeout_starts", start_cnt - s0, 1);
    check("timeout_clears", clr_cnt - c0, 2);
    check("timeout_valids", valid_cnt - v0, 0);
    hold_done_low = 1'b0;
    run_row(vecs[1]);
    check("error_sticky", int'(o_Error), 1);

    // Reset in the middle of harmonic 1: outputs zero at once, sample abandoned.
    v0 = valid_cnt;
    issue_req(3, 1'b1, 1500, 18);
    wait_harmonic(1);
    @(posedge i_Clock); #1;
    i_Reset = 1'b1;
    sb.delete();
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
    repeat (25) @(posedge i_Clock);
    #1;
    check("midreset_no_valid", valid_cnt - v0, 0);
    run_row(vecs[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
